// File: rtl/costas_pkg.sv
// costas_pkg: shared types for the Costas lock scheduler.
// FSM state enum, gain bundle, gain width and saturating |x| helper.
package costas_pkg;

  localparam int GAIN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_VERIFY = 2'd2,
    ST_TRACK  = 2'd3
  } costas_state_t;

  typedef struct packed {
    logic [GAIN_W-1:0] alpha;
    logic [GAIN_W-1:0] beta;
  } gain_t;

  // |x| for a w-bit two's complement value held sign-extended in x;
  // the most negative code saturates to the largest positive code.
  function automatic logic [31:0] sat_abs(
    input logic signed [31:0] x,
    input int                 w
  );
    logic signed [31:0] lo;
    lo = -(32'sd1 <<< (w - 1));
    if (x == lo) return (32'd1 << (w - 1)) - 32'd1;
    if (x < 0) return 32'(-x);
    return 32'(x);
  endfunction

endpackage

// File: rtl/costas_lock_metric.sv
// costas_lock_metric: windowed mean of min(|I|,|Q|) over 2^WIN_LOG2 symbols.
// Ports: clk/rst_n, clr (sync flush), sym_valid/sym_i/sym_q in; metric/metric_stb out.
module costas_lock_metric
  import costas_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int WIN_LOG2 = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     sym_valid,
  input  logic signed [DATA_W-1:0] sym_i,
  input  logic signed [DATA_W-1:0] sym_q,
  output logic        [DATA_W-2:0] metric,
  output logic                     metric_stb
);

  localparam int MW = DATA_W - 1;
  localparam int AW = MW + WIN_LOG2;

  logic [WIN_LOG2-1:0] cnt;
  logic [MW-1:0]       abs_i;
  logic [MW-1:0]       abs_q;
  logic [MW-1:0]       m;
  logic                v1;
  logic                last1;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       sum;

  always_comb begin
    m   = (abs_i < abs_q) ? abs_i : abs_q;
    sum = acc + AW'(m);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      abs_i      <= '0;
      abs_q      <= '0;
      v1         <= 1'b0;
      last1      <= 1'b0;
      acc        <= '0;
      metric     <= '0;
      metric_stb <= 1'b0;
    end else if (clr) begin
      cnt        <= '0;
      v1         <= 1'b0;
      last1      <= 1'b0;
      acc        <= '0;
      metric_stb <= 1'b0;
    end else begin
      v1         <= sym_valid;
      last1      <= sym_valid & (&cnt);
      metric_stb <= v1 & last1;
      if (sym_valid) begin
        cnt   <= cnt + WIN_LOG2'(1);
        abs_i <= MW'(sat_abs(32'(sym_i), DATA_W));
        abs_q <= MW'(sat_abs(32'(sym_q), DATA_W));
      end
      if (v1) begin
        if (last1) begin
          metric <= sum[AW-1:WIN_LOG2];
          acc    <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: rtl/costas_lock_sched.sv
// costas_lock_sched: ACQ/VERIFY/TRACK gain scheduler for the Costas loop.
// In: enable, symbol tap, thresholds, gain sets. Out: gains+gain_stb, loop_clr,
// locked, state, metric+metric_stb. COSTAS_SCHED_TIMEOUT_EN adds ACQ timeout clears.
module costas_lock_sched
  import costas_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int WIN_LOG2    = 6,
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_CNT  = 8,
  parameter int ACQ_TIMEOUT = 256
) (
  input  logic                     ce_clk,
  input  logic                     ce_rst_n,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] sym_i,
  input  logic signed [DATA_W-1:0] sym_q,
  input  logic                     sym_valid,
  input  logic        [DATA_W-2:0] lock_thresh,
  input  logic        [DATA_W-2:0] unlock_thresh,
  input  logic        [GAIN_W-1:0] acq_alpha,
  input  logic        [GAIN_W-1:0] acq_beta,
  input  logic        [GAIN_W-1:0] trk_alpha,
  input  logic        [GAIN_W-1:0] trk_beta,
  output logic        [GAIN_W-1:0] alpha_out,
  output logic        [GAIN_W-1:0] beta_out,
  output logic                     gain_stb,
  output logic                     loop_clr,
  output logic                     locked,
  output logic        [1:0]        state,
  output logic        [DATA_W-2:0] metric,
  output logic                     metric_stb
);

  localparam int GCW = $clog2(LOCK_CNT + 1);
  localparam int BCW = $clog2(UNLOCK_CNT + 1);

  costas_state_t  st_q, st_d;
  gain_t          gain_q, gain_d;
  gain_t          acq_g, trk_g;
  logic [GCW-1:0] good_q, good_d;
  logic [BCW-1:0] bad_q, bad_d;
  logic           gstb_d, clr_d, to_hit;
  logic           good_win, bad_win;
  logic           sym_acc, m_clr;

  assign acq_g   = {acq_alpha, acq_beta};
  assign trk_g   = {trk_alpha, trk_beta};
  assign sym_acc = sym_valid & enable & (st_q != ST_IDLE);
  assign m_clr   = ~enable | (st_q == ST_IDLE);

  costas_lock_metric #(
    .DATA_W   (DATA_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_metric (
    .clk        (ce_clk),
    .rst_n      (ce_rst_n),
    .clr        (m_clr),
    .sym_valid  (sym_acc),
    .sym_i      (sym_i),
    .sym_q      (sym_q),
    .metric     (metric),
    .metric_stb (metric_stb)
  );

  assign good_win = metric >= lock_thresh;
  assign bad_win  = metric < unlock_thresh;

  always_comb begin
    st_d   = st_q;
    gain_d = gain_q;
    gstb_d = 1'b0;
    clr_d  = 1'b0;
    good_d = good_q;
    bad_d  = bad_q;
    if (!enable) begin
      st_d   = ST_IDLE;
      good_d = '0;
      bad_d  = '0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          st_d   = ST_ACQ;
          gain_d = acq_g;
          gstb_d = 1'b1;
        end
        ST_ACQ: begin
          if (metric_stb && good_win) begin
            st_d   = ST_VERIFY;
            good_d = GCW'(1);
          end
        end
        ST_VERIFY: begin
          if (metric_stb) begin
            if (good_win) begin
              good_d = good_q + GCW'(1);
              if (good_d == GCW'(LOCK_CNT)) begin
                st_d   = ST_TRACK;
                gain_d = trk_g;
                gstb_d = 1'b1;
                bad_d  = '0;
              end
            end else begin
              st_d = ST_ACQ;
            end
          end
        end
        ST_TRACK: begin
          if (metric_stb) begin
            if (bad_win) begin
              bad_d = bad_q + BCW'(1);
              if (bad_d == BCW'(UNLOCK_CNT)) begin
                st_d   = ST_ACQ;
                gain_d = acq_g;
                gstb_d = 1'b1;
                clr_d  = 1'b1;
                bad_d  = '0;
              end
            end else begin
              bad_d = '0;
            end
          end
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

`ifdef COSTAS_SCHED_TIMEOUT_EN
  localparam int TCW = $clog2(ACQ_TIMEOUT + 1);

  logic [TCW-1:0] to_q, to_d;

  // Counts bad windows while resident in ACQ; any other path resets it,
  // so entering ACQ always starts from zero.
  always_comb begin
    to_d   = to_q;
    to_hit = 1'b0;
    if (!enable || st_q != ST_ACQ || st_d != ST_ACQ) begin
      to_d = '0;
    end else if (metric_stb) begin
      if (to_q == TCW'(ACQ_TIMEOUT - 1)) begin
        to_hit = 1'b1;
        to_d   = '0;
      end else begin
        to_d = to_q + TCW'(1);
      end
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) to_q <= '0;
    else           to_q <= to_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      st_q     <= ST_IDLE;
      gain_q   <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      gain_stb <= 1'b0;
      loop_clr <= 1'b0;
      locked   <= 1'b0;
    end else begin
      st_q     <= st_d;
      gain_q   <= gain_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      gain_stb <= gstb_d;
      loop_clr <= clr_d | to_hit;
      locked   <= (st_d == ST_TRACK);
    end
  end

  assign state     = st_q;
  assign alpha_out = gain_q.alpha;
  assign beta_out  = gain_q.beta;

endmodule

// File: tb/tb_costas_lock_sched.sv
// tb_costas_lock_sched: directed + randomized bench for costas_lock_sched
// against a window/event-level reference model.
module tb_costas_lock_sched;

  localparam int DW  = 16;
  localparam int WL  = 2;
  localparam int WIN = 4;
  localparam int LC  = 4;
  localparam int UC  = 8;
  localparam int AT  = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic signed [15:0] sym_i = '0;
  logic signed [15:0] sym_q = '0;
  logic               sym_valid = 1'b0;
  logic [14:0]        lock_thresh = 15'h1000;
  logic [14:0]        unlock_thresh = 15'h0800;
  logic [15:0]        acq_alpha = 16'h0400;
  logic [15:0]        acq_beta = 16'h0020;
  logic [15:0]        trk_alpha = 16'h0100;
  logic [15:0]        trk_beta = 16'h0008;
  logic [15:0]        alpha_out, beta_out;
  logic               gain_stb, loop_clr, locked, metric_stb;
  logic [1:0]         state;
  logic [14:0]        metric;

  always #5 clk = ~clk;

  costas_lock_sched #(
    .DATA_W      (DW),
    .WIN_LOG2    (WL),
    .LOCK_CNT    (LC),
    .UNLOCK_CNT  (UC),
    .ACQ_TIMEOUT (AT)
  ) dut (
    .ce_clk        (clk),
    .ce_rst_n      (rst_n),
    .enable        (enable),
    .sym_i         (sym_i),
    .sym_q         (sym_q),
    .sym_valid     (sym_valid),
    .lock_thresh   (lock_thresh),
    .unlock_thresh (unlock_thresh),
    .acq_alpha     (acq_alpha),
    .acq_beta      (acq_beta),
    .trk_alpha     (trk_alpha),
    .trk_beta      (trk_beta),
    .alpha_out     (alpha_out),
    .beta_out      (beta_out),
    .gain_stb      (gain_stb),
    .loop_clr      (loop_clr),
    .locked        (locked),
    .state         (state),
    .metric        (metric),
    .metric_stb    (metric_stb)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_clr = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_st = 0, m_good = 0, m_bad = 0, m_to = 0;
  int          m_metric = 0, wsum = 0, wn = 0, cyc = 0, prev = 0;
  logic [15:0] m_alpha = '0, m_beta = '0;
  bit          m_gstb = 0, m_clr = 0, m_mstb = 0;
  int          mq_due[$], mq_val[$], dq_due[$], dq_val[$];

  function automatic int mag(input logic signed [15:0] x);
    int v;
    v = x;
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  task automatic decide(input int v);
    case (m_st)
      1: begin
        if (v >= int'(lock_thresh)) begin
          m_st = 2;
          m_good = 1;
        end else begin
          m_to++;
`ifdef COSTAS_SCHED_TIMEOUT_EN
          if (m_to == AT) begin
            m_clr = 1;
            m_to = 0;
          end
`endif
        end
      end
      2: begin
        if (v >= int'(lock_thresh)) begin
          m_good++;
          if (m_good == LC) begin
            m_st = 3;
            m_alpha = trk_alpha;
            m_beta = trk_beta;
            m_gstb = 1;
            m_bad = 0;
          end
        end else begin
          m_st = 1;
          m_to = 0;
        end
      end
      3: begin
        if (v < int'(unlock_thresh)) begin
          m_bad++;
          if (m_bad == UC) begin
            m_st = 1;
            m_alpha = acq_alpha;
            m_beta = acq_beta;
            m_gstb = 1;
            m_clr = 1;
            m_to = 0;
            m_bad = 0;
          end
        end else begin
          m_bad = 0;
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_good = 0; m_bad = 0; m_to = 0;
      m_metric = 0; wsum = 0; wn = 0;
      m_alpha = '0; m_beta = '0;
      m_gstb = 0; m_clr = 0; m_mstb = 0;
      mq_due.delete(); mq_val.delete();
      dq_due.delete(); dq_val.delete();
    end else begin
      cyc++;
      m_gstb = 0; m_clr = 0; m_mstb = 0;
      if (!enable) begin
        m_st = 0; m_good = 0; m_bad = 0; m_to = 0;
        wsum = 0; wn = 0;
        mq_due.delete(); mq_val.delete();
        dq_due.delete(); dq_val.delete();
      end else begin
        prev = m_st;
        if (dq_due.size() > 0 && dq_due[0] == cyc) begin
          void'(dq_due.pop_front());
          decide(dq_val.pop_front());
        end
        if (mq_due.size() > 0 && mq_due[0] == cyc) begin
          void'(mq_due.pop_front());
          m_metric = mq_val.pop_front();
          m_mstb = 1;
          dq_due.push_back(cyc + 1);
          dq_val.push_back(m_metric);
        end
        if (prev == 0) begin
          m_st = 1;
          m_alpha = acq_alpha;
          m_beta = acq_beta;
          m_gstb = 1;
          m_to = 0;
        end else if (sym_valid) begin
          wsum += (mag(sym_i) < mag(sym_q)) ? mag(sym_i) : mag(sym_q);
          wn++;
          if (wn == WIN) begin
            mq_due.push_back(cyc + 1);
            mq_val.push_back(wsum / WIN);
            wsum = 0;
            wn = 0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("state", 32'(state), 32'(m_st));
      chk("locked", 32'(locked), 32'(m_st == 3));
      chk("alpha", 32'(alpha_out), 32'(m_alpha));
      chk("beta", 32'(beta_out), 32'(m_beta));
      chk("gain_stb", 32'(gain_stb), 32'(m_gstb));
      chk("loop_clr", 32'(loop_clr), 32'(m_clr));
      chk("metric_stb", 32'(metric_stb), 32'(m_mstb));
      chk("metric", 32'(metric), 32'(m_metric));
      if (loop_clr) n_clr++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic sym(input int i, input int q);
    @(negedge clk);
    sym_valid = 1'b1;
    sym_i = 16'(i);
    sym_q = 16'(q);
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      sym_valid = 1'b0;
    end
  endtask

  task automatic window(input int i, input int q);
    repeat (WIN) sym(i, q);
  endtask

  function automatic logic signed [15:0] rnd(input int lo, input int hi);
    int v;
    v = int'($urandom_range(hi, lo));
    return ($urandom_range(1, 0) == 1) ? 16'(-v) : 16'(v);
  endfunction

  int regime = 0;
  int exp_clr;

  initial begin
    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_alpha", 32'(alpha_out), 32'd0);
    chk("rst_metric", 32'(metric), 32'd0);
    idle_cyc(2);
    rst_n = 1'b1;
    idle_cyc(1);

    // enable -> ACQ with acquisition gains
    enable = 1'b1;
    @(negedge clk);
    chk("en_gstb", 32'(gain_stb), 32'd1);
    chk("en_state", 32'(state), 32'd1);
    chk("en_alpha", 32'(alpha_out), 32'h0400);
    chk("en_beta", 32'(beta_out), 32'h0020);

    // four good windows -> TRACK
    repeat (LC) window(16'h2000, -16'h2000);
    idle_cyc(2);
    chk("lk_metric", 32'(metric), 32'h2000);
    chk("lk_mstb", 32'(metric_stb), 32'd1);
    idle_cyc(1);
    chk("lk_state", 32'(state), 32'd3);
    chk("lk_locked", 32'(locked), 32'd1);
    chk("lk_alpha", 32'(alpha_out), 32'h0100);
    chk("lk_gstb", 32'(gain_stb), 32'd1);

    // 7 bad + 1 good: stays locked; then 8 bad: drop to ACQ
    repeat (UC - 1) window(16'h2000, 0);
    window(16'h2000, 16'h2000);
    idle_cyc(3);
    chk("hold_state", 32'(state), 32'd3);
    repeat (UC) window(16'h2000, 0);
    idle_cyc(3);
    chk("ul_state", 32'(state), 32'd1);
    chk("ul_clr", 32'(loop_clr), 32'd1);
    chk("ul_gstb", 32'(gain_stb), 32'd1);
    chk("ul_alpha", 32'(alpha_out), 32'h0400);

    // saturation of the most negative code
    window(-32768, -32768);
    idle_cyc(2);
    chk("sat_metric", 32'(metric), 32'h7FFF);
    idle_cyc(1);

    // zero windows: one kicks VERIFY back to ACQ, eight more sit in ACQ
    n_clr = 0;
    repeat (9) window(0, 0);
    idle_cyc(4);
`ifdef COSTAS_SCHED_TIMEOUT_EN
    exp_clr = 2;
`else
    exp_clr = 0;
`endif
    chk("to_pulses", 32'(n_clr), 32'(exp_clr));
    chk("to_state", 32'(state), 32'd1);

    // disable on the window-end symbol
    repeat (WIN - 1) sym(16'h2000, 16'h2000);
    @(negedge clk);
    sym_valid = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    sym_valid = 1'b0;
    chk("dis_state", 32'(state), 32'd0);
    chk("dis_alpha", 32'(alpha_out), 32'h0400);
    repeat (3) begin
      @(negedge clk);
      chk("dis_mstb", 32'(metric_stb), 32'd0);
    end
    enable = 1'b1;
    idle_cyc(2);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 32 == 0) regime = int'($urandom_range(2, 0));
      if (enable && $urandom_range(299, 0) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(2, 0) == 0) enable = 1'b1;
      sym_valid = ($urandom_range(3, 0) != 0);
      if ($urandom_range(49, 0) == 0) begin
        sym_i = 16'sh8000;
        sym_q = 16'sh8000;
      end else if (regime == 0) begin
        sym_i = rnd(16'h1000, 16'h2400);
        sym_q = rnd(16'h1000, 16'h2400);
      end else if (regime == 1) begin
        sym_i = rnd(0, 16'h0C00);
        sym_q = rnd(0, 16'h2400);
      end else begin
        sym_i = rnd(0, 16'h2400);
        sym_q = rnd(0, 16'h2400);
      end
      if ($urandom_range(99, 0) == 0) begin
        acq_alpha = 16'($urandom);
        acq_beta = 16'($urandom);
        trk_alpha = 16'($urandom);
        trk_beta = 16'($urandom);
      end
      if ($urandom_range(199, 0) == 0) begin
        lock_thresh = 15'($urandom_range(16'h1400, 16'h0800));
        unlock_thresh = 15'($urandom_range(16'h0C00, 16'h0400));
      end
    end
    enable = 1'b1;
    idle_cyc(6);

    // asynchronous reset mid-window
    sym(16'h2000, 16'h2000);
    sym(16'h2000, 16'h2000);
    @(negedge clk);
    sym_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_alpha", 32'(alpha_out), 32'd0);
    chk("ar_beta", 32'(beta_out), 32'd0);
    chk("ar_metric", 32'(metric), 32'd0);
    chk("ar_locked", 32'(locked), 32'd0);
    chk("ar_gstb", 32'(gain_stb), 32'd0);
    idle_cyc(2);
    rst_n = 1'b1;
    idle_cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/costas_lock_sched.md
# costas_lock_sched

Acquisition/tracking scheduler for the Costas carrier-recovery loop inside `rfnoc_block_costas`. It taps the derotated QPSK symbol stream and computes a windowed lock metric. An FSM uses that metric to switch the loop filter between wide acquisition gains and narrow tracking gains. It also requests a loop clear when lock is lost or acquisition times out. It sits between the user-register file and the loop filter's coefficient inputs, and it observes the datapath without stalling it.

## Interface
- `DATA_W`, 16: signed width of the I and Q symbol components.
- `WIN_LOG2`, 6: log2 of the window length in symbols (64 symbols = one SPP packet).
- `LOCK_CNT`, 4: consecutive good windows required in VERIFY before entering TRACK.
- `UNLOCK_CNT`, 8: consecutive bad windows in TRACK that declare loss of lock.
- `ACQ_TIMEOUT`, 256: number of windows in ACQ before a forced loop clear.
- `ce_clk` in 1: block clock (the CE domain).
- `ce_rst_n` in 1: reset, asynchronous assert, active-low.
- `enable` in 1: scheduler run; when 0 the block is forced to IDLE.
- `sym_i`, `sym_q` in DATA_W each: derotated symbol, two's complement.
- `sym_valid` in 1: symbol strobe. The tap is observe-only; there is no ready.
- `lock_thresh`, `unlock_thresh` in DATA_W-1 each: thresholds applied to the window mean.
- `acq_alpha`, `acq_beta`, `trk_alpha`, `trk_beta` in 16 each: loop gain sets.
- `alpha_out`, `beta_out` out 16 each: gains currently applied to the loop filter.
- `gain_stb` out 1: one-cycle pulse when `alpha_out`/`beta_out` change.
- `loop_clr` out 1: one-cycle pulse requesting the loop filter/NCO to clear its integrators.
- `locked` out 1: high in TRACK only.
- `state` out 2: current FSM state.
- `metric` out DATA_W-1: latest window mean.
- `metric_stb` out 1: one-cycle pulse when `metric` updates.

## Operation
- Per-symbol value: m = min(|I|,|Q|). |−2^(DATA_W−1)| saturates to 2^(DATA_W−1)−1.
- Window accumulation:
  - The accumulator is DATA_W−1+WIN_LOG2 bits wide and cannot overflow.
  - The symbol counter is WIN_LOG2 bits and wraps to 0 at the end of each window.
  - The window mean is sum >> WIN_LOG2 (truncated).
  - At window end the accumulator restarts with that cycle's symbol excluded. The next window starts at the next symbol.
- FSM states and encoding: IDLE=0, ACQ=1, VERIFY=2, TRACK=3. Window evaluation uses the thresholds as sampled on the `metric_stb` cycle.
  - IDLE → ACQ when `enable`=1. Load acq gains and pulse `gain_stb`.
  - ACQ, window with mean ≥ `lock_thresh` → VERIFY, good count = 1.
  - ACQ, otherwise → stay in ACQ and increment the timeout counter.
  - VERIFY, good window → increment the good count; when it reaches LOCK_CNT → TRACK. Load trk gains and pulse `gain_stb`.
  - VERIFY, bad window → ACQ. Gains are unchanged.
  - TRACK, mean < `unlock_thresh` → increment the bad count.
  - TRACK, mean ≥ `unlock_thresh` → clear the bad count.
  - TRACK, bad count reaches UNLOCK_CNT → ACQ. Load acq gains and pulse `gain_stb` and `loop_clr` in the same cycle.
  - Hysteresis is the user's responsibility (`unlock_thresh` ≤ `lock_thresh`). No check is performed.
- Gain inputs are sampled only on transitions. Changing them mid-state has no effect until the next transition.
- `enable`=0 in any state → IDLE on the next edge. This clears the accumulator, symbol counter and all window counters, and holds the gains. `sym_valid` is ignored in IDLE.
- If `enable` falls on the same cycle as a window end, disable wins and no metric decision is taken.

## Timing
- Reset values:
  - `state`=IDLE, `locked`=0.
  - `alpha_out`=`beta_out`=0.
  - `gain_stb`=`loop_clr`=`metric_stb`=0, `metric`=0.
  - Accumulator, symbol counter and all window counters = 0.
- Metric pipeline, for the last symbol of a window accepted at cycle t:
  - cycle t+1: |I|,|Q| registered.
  - cycle t+2: `metric` and `metric_stb` valid.
  - cycle t+3: new `state`, `alpha_out`/`beta_out`, `gain_stb`, `loop_clr` and `locked` valid.
- Back-to-back `sym_valid` (one per cycle) is supported with no gaps. Consecutive windows are evaluated independently.
- IDLE → ACQ: `gain_stb` occurs one cycle after `enable` is first sampled high.
- All outputs are registered. Pulses last exactly one cycle.

## Configuration
- `COSTAS_SCHED_TIMEOUT_EN` defined:
  - When the ACQ timeout counter reaches ACQ_TIMEOUT windows, pulse `loop_clr` and reset the counter, staying in ACQ.
  - The counter clears on entering ACQ from any state.
- Not defined: there is no timeout logic or counter, and ACQ waits indefinitely.

## Structure
- The shared package `costas_pkg` holds:
  - the `costas_state_t` enum (2-bit, with the encodings above);
  - the gain width localparam (16);
  - the function `sat_abs` used for |x|.
- Sub-module `costas_lock_metric` implements the abs/min stage, the accumulator, the symbol counter and `metric`/`metric_stb`. The top level holds the FSM, the counters and the gain registers.

## Test plan
- Reset, then `enable`=1, with acq=(0x0400,0x0020) → `gain_stb` pulses once, `alpha_out`=0x0400, `beta_out`=0x0020, `state`=1.
- WIN_LOG2=2, LOCK_CNT=4, `lock_thresh`=0x1000, with symbols (0x2000,−0x2000) back-to-back → `metric`=0x2000 every 4 symbols; VERIFY after window 1; TRACK and `locked`=1 plus trk gains three cycles after the last symbol of window 4.
- In TRACK with `unlock_thresh`=0x0800, UNLOCK_CNT=8, feed symbols (0x2000,0x0000) → after 8 windows a single-cycle `loop_clr` and `gain_stb`, and `state`=1. Inserting one good window after 7 bad ones prevents the drop.
- Symbol (−0x8000,−0x8000) for a whole window → `metric`=0x7FFF (saturation).
- With `COSTAS_SCHED_TIMEOUT_EN` and ACQ_TIMEOUT=3, feed zero symbols → `loop_clr` pulses every 3 windows and `state` stays 1. Without the macro there is no pulse.
- Deassert `enable` on the same cycle as a window-end symbol → `state`=0 next edge, no `metric_stb` decision, gains held. Asserting `ce_rst_n` low mid-window returns all outputs to their reset values immediately.
